// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Round-robin memory bus arbiter with turnaround gap and hold watchdog.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
    parameter int N_CLIENTS  = 4,
    parameter int HOLD_MAX   = 64,
    parameter int GAP_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         nRst,
    input  logic [N_CLIENTS-1:0]         request,
    output logic [N_CLIENTS-1:0]         grant,
    output logic                         grant_valid,
    output logic [$clog2(N_CLIENTS)-1:0] grant_id,
    output logic                         timeout,
    output logic [$clog2(N_CLIENTS)-1:0] timeout_id
);

    localparam int c_IW = $clog2(N_CLIENTS);
    localparam int c_PW = c_IW + 1;
    localparam int c_HW = $clog2(HOLD_MAX + 1);
    localparam int c_GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_GRANTED = 2'd1;
    localparam logic [1:0] c_GAP     = 2'd2;

    logic [1:0]           r_state;
    logic [c_IW-1:0]      r_rr_ptr;
    logic [c_HW-1:0]      r_hold;
    logic [c_GW-1:0]      r_gap;
    logic [N_CLIENTS-1:0] r_mask;
    logic [N_CLIENTS-1:0] r_grant;
    logic                 r_grant_valid;
    logic [c_IW-1:0]      r_grant_id;
    logic                 r_timeout;
    logic [c_IW-1:0]      r_timeout_id;

    logic [N_CLIENTS-1:0] w_eligible;
    logic [N_CLIENTS-1:0] w_winner_oh;
    logic [c_PW-1:0]      w_sum;
    logic [c_IW-1:0]      w_winner;
    logic [c_IW-1:0]      w_next_ptr;
    logic                 w_found;
    logic                 w_owner_req;
    logic                 w_hold_max;
    logic                 w_gap_done;
    logic                 w_do_grant;
    logic                 w_do_release;
    logic                 w_do_timeout;

    assign w_eligible = request & ~r_mask;

    // Walk upward from rr_ptr with wraparound; the first eligible client wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            w_sum = {1'b0, r_rr_ptr} + c_PW'(i);
            if (w_sum >= c_PW'(N_CLIENTS)) begin
                w_sum = w_sum - c_PW'(N_CLIENTS);
            end
            if (!w_found && w_eligible[w_sum[c_IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[c_IW-1:0];
            end
        end
    end

    assign w_winner_oh  = {{(N_CLIENTS-1){1'b0}}, 1'b1} << w_winner;
    assign w_next_ptr   = (w_winner == c_IW'(N_CLIENTS - 1)) ? '0 : w_winner + c_IW'(1);
    assign w_owner_req  = request[r_grant_id];
    assign w_hold_max   = (r_hold == c_HW'(HOLD_MAX));
    assign w_gap_done   = (r_gap == c_GW'(GAP_CYCLES));

    assign w_do_grant   = w_found && ((r_state == c_IDLE) || ((r_state == c_GAP) && w_gap_done));
    assign w_do_release = (r_state == c_GRANTED) && (!w_owner_req || w_hold_max);
    assign w_do_timeout = (r_state == c_GRANTED) && w_owner_req && w_hold_max;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state       <= c_IDLE;
            r_rr_ptr      <= '0;
            r_hold        <= '0;
            r_gap         <= '0;
            r_mask        <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_timeout     <= 1'b0;
            r_timeout_id  <= '0;
        end else begin
            r_timeout <= 1'b0;
            // A mask bit only survives while its client keeps requesting.
            r_mask    <= r_mask & request;

            if (w_do_grant) begin
                r_grant       <= w_winner_oh;
                r_grant_valid <= 1'b1;
                r_grant_id    <= w_winner;
                r_rr_ptr      <= w_next_ptr;
                r_hold        <= c_HW'(1);
                r_gap         <= '0;
                r_state       <= c_GRANTED;
            end else if (w_do_release) begin
                r_grant       <= '0;
                r_grant_valid <= 1'b0;
                r_grant_id    <= '0;
                r_hold        <= '0;
                r_gap         <= c_GW'(1);
                r_state       <= c_GAP;
            end else begin
                case (r_state)
                    c_GRANTED: r_hold <= r_hold + c_HW'(1);
                    c_GAP: begin
                        if (!w_gap_done) begin
                            r_gap <= r_gap + c_GW'(1);
                        end else begin
                            r_gap   <= '0;
                            r_state <= c_IDLE;
                        end
                    end
                    c_IDLE:  r_state <= c_IDLE;
                    default: r_state <= c_IDLE;
                endcase
            end

            if (w_do_timeout) begin
                r_timeout            <= 1'b1;
                r_timeout_id         <= r_grant_id;
                r_mask[r_grant_id]   <= 1'b1;
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign timeout     = r_timeout;
    assign timeout_id  = r_timeout_id;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Scoreboard bench for mem_bus_arbiter against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int N    = 4;
    localparam int HMAX = 8;
    localparam int GAPC = 1;

    typedef struct {
        logic [N-1:0] grant;
        logic         gv;
        logic [1:0]   gid;
        logic         to;
        logic [1:0]   toid;
    } exp_t;

    logic         clk = 1'b0;
    logic         nRst;
    logic [N-1:0] request;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         timeout;
    logic [1:0]   timeout_id;

    int n_checks = 0;
    int n_err    = 0;
    exp_t q[$];

    // Model state: owner index (-1 = bus free), cycles held, gap progress.
    int       m_owner = -1;
    int       m_hold  = 0;
    int       m_gap   = 0;
    bit       m_ingap = 0;
    bit       m_mask[N];
    int       m_ptr   = 0;
    bit       m_to    = 0;
    int       m_toid  = 0;

    // Client behaviour for the reactive phases.
    logic [N-1:0] req;
    int           cnt[N];
    int           hl[N];
    int           hlfix[N];
    int           off[N];

    mem_bus_arbiter #(.N_CLIENTS(N), .HOLD_MAX(HMAX), .GAP_CYCLES(GAPC)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .request     (request),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout),
        .timeout_id  (timeout_id)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [N-1:0] r, input logic rn);
        exp_t e;
        if (!rn) begin
            m_owner = -1; m_hold = 0; m_gap = 0; m_ingap = 0; m_ptr = 0;
            m_to = 0; m_toid = 0;
            for (int i = 0; i < N; i++) m_mask[i] = 0;
        end else begin
            bit elig[N];
            for (int i = 0; i < N; i++) begin
                elig[i] = r[i] && !m_mask[i];
                if (!r[i]) m_mask[i] = 0;
            end
            m_to = 0;
            if (m_owner >= 0) begin
                if (!r[m_owner]) begin
                    m_owner = -1; m_ingap = 1; m_gap = 1;
                end else if (m_hold == HMAX) begin
                    m_to = 1; m_toid = m_owner; m_mask[m_owner] = 1;
                    m_owner = -1; m_ingap = 1; m_gap = 1;
                end else begin
                    m_hold++;
                end
            end else if (m_ingap && m_gap < GAPC) begin
                m_gap++;
            end else begin
                m_ingap = 0;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (m_owner < 0 && elig[c]) begin
                        m_owner = c; m_hold = 1; m_ptr = (c + 1) % N;
                    end
                end
            end
        end
        e.grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.gv    = (m_owner >= 0);
        e.gid   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.to    = m_to;
        e.toid  = 2'(m_toid);
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(request, nRst);
        #1;
    endtask

    task automatic react(input bit rnd, input logic [N-1:0] en);
        for (int c = 0; c < N; c++) begin
            if (req[c]) begin
                if (!en[c]) begin
                    req[c] = 0; cnt[c] = 0; off[c] = 0;
                end else if (m_owner == c) begin
                    cnt[c]++;
                    if (cnt[c] >= hl[c]) begin
                        req[c] = 0; cnt[c] = 0;
                        off[c] = rnd ? int'($urandom_range(0, 6)) : 0;
                    end
                end else if (rnd && $urandom_range(0, 15) == 0) begin
                    req[c] = 0; cnt[c] = 0; off[c] = int'($urandom_range(0, 6));
                end
            end else if (off[c] > 0) begin
                off[c]--;
            end else if (en[c] && (!rnd || $urandom_range(0, 3) == 0)) begin
                req[c] = 1; cnt[c] = 0;
                hl[c]  = rnd ? int'($urandom_range(1, 12)) : hlfix[c];
            end
        end
    endtask

    task automatic run_react(input int cycles, input bit rnd, input logic [N-1:0] en);
        repeat (cycles) begin
            tick();
            react(rnd, en);
            request = req;
            if (rnd) nRst = ($urandom_range(0, 499) != 0);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("grant",       32'(grant),       32'(e.grant));
                check("grant_valid", 32'(grant_valid), 32'(e.gv));
                check("grant_id",    32'(grant_id),    32'(e.gid));
                check("timeout",     32'(timeout),     32'(e.to));
                if (e.to) check("timeout_id", 32'(timeout_id), 32'(e.toid));
                check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            end
        end
    end

    initial begin : driver
        logic [N-1:0] prio_tbl[15];
        prio_tbl = '{4'b0100, 4'b0101, 4'b0101, 4'b0001, 4'b0101, 4'b0101, 4'b0101,
                     4'b0101, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                     4'b0000};
        request = '0;
        nRst    = 1'b0;
        req     = '0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; hl[i] = 1; hlfix[i] = 3; off[i] = 0; m_mask[i] = 0;
        end
        repeat (3) tick();
        nRst = 1'b1;

        // Single request from client 1
        repeat (4) tick();
        request = 4'b0010;
        repeat (5) tick();
        request = 4'b0000;
        repeat (4) tick();

        // Round robin, every owner releases after 3 granted cycles
        req = request;
        run_react(24, 1'b0, 4'b1111);
        run_react(3, 1'b0, 4'b0000);

        // Priority after release
        foreach (prio_tbl[i]) begin
            request = prio_tbl[i];
            tick();
        end

        // Watchdog: client 3 stuck, client 1 well behaved
        req = request;
        hlfix[3] = 1000;
        run_react(30, 1'b0, 4'b1010);
        run_react(3, 1'b0, 4'b0000);
        run_react(15, 1'b0, 4'b1010);
        run_react(3, 1'b0, 4'b0000);

        // Sole stuck client 0
        hlfix[0] = 1000;
        run_react(25, 1'b0, 4'b0001);
        run_react(2, 1'b0, 4'b0000);
        run_react(14, 1'b0, 4'b0001);
        run_react(3, 1'b0, 4'b0000);

        // Reset while client 2 owns the bus
        request = 4'b0100;
        repeat (3) tick();
        request = 4'b0111;
        tick();
        nRst = 1'b0;
        tick();
        nRst = 1'b1;
        repeat (6) tick();
        request = 4'b0000;
        repeat (3) tick();

        // Randomised traffic with occasional resets
        req = request;
        run_react(3000, 1'b1, 4'b1111);
        nRst = 1'b1;
        request = '0;
        repeat (4) tick();

        @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Round-robin arbiter that shares the single memory write/read bus between up to N_CLIENTS bus masters (memory writers, readers, SPI/MIL-side engines). Each client raises request, waits for its one-hot grant, drives the tri-stated memory bus while granted, then drops request. The arbiter enforces a bus-turnaround gap between owners and a hold-time watchdog, so a stuck client cannot starve the others.

Parameters:
N_CLIENTS, 4, number of requesters (2..8)
HOLD_MAX, 64, max consecutive cycles one client may hold grant (>=2)
GAP_CYCLES, 1, idle cycles with no grant between two owners (>=1)

Ports:
clk  input  1  system clock
nRst  input  1  synchronous active-low reset
request  input  N_CLIENTS  per-client request, level, held until done
grant  output  N_CLIENTS  one-hot (or zero) grant, registered
grant_valid  output  1  OR of grant, registered
grant_id  output  $clog2(N_CLIENTS)  index of current owner; 0 when none
timeout  output  1  one-cycle pulse when a grant is revoked by watchdog
timeout_id  output  $clog2(N_CLIENTS)  index of revoked client, valid with timeout

Behaviour:
- Single clock, synchronous active-low reset: on any rising clk with nRst=0, grant=0, grant_valid=0, grant_id=0, timeout=0, timeout_id=0, state=IDLE, rr_ptr=0, hold counter=0, gap counter=0, mask=0. Reset mid-grant drops grant at that same edge.
- All outputs are registered; grant never more than one-hot.
- FSM states: IDLE, GRANTED, GAP.
- Eligible set = request & ~mask. Winner = first eligible index searching upward from rr_ptr, wrapping modulo N_CLIENTS.
- IDLE: if eligible set non-empty at edge -> grant[winner]=1, grant_id=winner, hold=1, rr_ptr=(winner+1) mod N, -> GRANTED. Latency: request first high in cycle k, grant high in cycle k+1.
- GRANTED: owner's request sampled each edge.
  - request[owner]=0 -> grant=0, -> GAP, gap counter=1.
  - request[owner]=1 and hold==HOLD_MAX -> grant=0, timeout=1 for one cycle, timeout_id=owner, mask[owner]=1, -> GAP.
  - else hold increments; grant stays. Owner holds for at most HOLD_MAX cycles.
  - Requests of other clients while GRANTED are ignored, not latched.
- GAP: all grants low. If gap counter<GAP_CYCLES, it increments. If gap counter==GAP_CYCLES: if eligible non-empty, grant winner at this edge (-> GRANTED); else -> IDLE. Result: grant low for exactly GAP_CYCLES cycles between consecutive owners.
- Mask: mask[i] clears at any edge where request[i]=0. A masked client is never granted, even if it is the only requester, until it has dropped request for at least one cycle.
- Round robin: the previous owner has lowest priority at the next arbitration. A sole requester is re-granted after the gap.
- Request withdrawn before grant: no grant is issued and no state is kept.
- grant_id holds last owner only while granted; it returns to 0 when grant_valid=0.

Test Plan:
- Single request: N=4, request=0010 from cycle 5 -> grant=0010, grant_id=1 in cycle 6. Drop request in cycle 10 -> grant=0 in cycle 11. Idle thereafter.
- Round robin: request=1111 held, each owner releases after 3 cycles of grant -> grant order 0,1,2,3,0. Exactly GAP_CYCLES=1 zero-grant cycle between each owner.
- Priority after release: client 2 owns the bus, request=0101 pending -> next grant goes to 0 (search from 3 wraps to 0). The cycle after, client 2 re-requests -> it is served after client 0.
- Watchdog: HOLD_MAX=8, client 3 holds request forever, client 1 requests -> grant[3] high for exactly 8 cycles. Then timeout=1, timeout_id=3 for one cycle. Client 1 is granted after the gap. Client 3 is not regranted until its request drops for 1 cycle and rises again.
- Sole stuck client: only client 0 requests continuously -> it is granted 8 cycles, then timeout fires, then no grant at all until request[0] toggles low.
- Reset mid-operation: nRst=0 while grant=0100 -> next edge all outputs 0. With request still high after nRst returns to 1, grant reappears one cycle later, with rr_ptr=0 ordering.
